// File: rtl/inference_sequencer.sv
// inference_sequencer: steps the multiplier through every output row of one
// classification pass, strobes each row result into the result registers and
// keeps sticky per-row overflow flags plus a running signed argmax.
module inference_sequencer #(
  parameter int NUM_ROWS       = 10,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                i_clk,
  input  logic                i_n_rst,
  input  logic                i_start_calc,
  input  logic                i_abort,
  input  logic                i_done_row,
  input  logic                i_overflow,
  input  logic [15:0]         i_row_result,
  output logic [3:0]          o_row_select,
  output logic                o_begin_mult,
  output logic [3:0]          o_in_sel,
  output logic                o_w_result_ena,
  output logic                o_clear_data,
  output logic                o_busy,
  output logic                o_done_calc,
  output logic                o_timeout_err,
  output logic [NUM_ROWS-1:0] o_ovf_flags,
  output logic [3:0]          o_best_class,
  output logic [15:0]         o_best_value
);

  localparam int                CNT_W    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]        LAST_ROW = 4'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_DONE,
    S_ERR
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_row;
  logic [CNT_W-1:0]     r_cnt;
  logic signed [15:0]   r_cap;
  logic                 r_cap_ovf;
  logic [NUM_ROWS-1:0]  r_ovf_flags;
  logic [3:0]           r_best_class;
  logic signed [15:0]   r_best_value;

  // State register; reset returns to IDLE from anywhere, even mid-pass.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; abort wins over done_row and the timeout in busy states.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start_calc) w_next_state = S_CLEAR;
      end
      S_CLEAR: begin
        w_next_state = i_abort ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        w_next_state = i_abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (i_done_row) begin
          w_next_state = S_STORE;
        end else if (r_cnt == CNT_MAX) begin
          w_next_state = S_ERR;
        end
      end
      S_STORE: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (r_row == LAST_ROW) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_DONE, S_ERR: begin
        if (i_start_calc) w_next_state = S_CLEAR;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Row index, timeout counter, capture register, overflow flags and argmax.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_row        <= '0;
      r_cnt        <= '0;
      r_cap        <= '0;
      r_cap_ovf    <= 1'b0;
      r_ovf_flags  <= '0;
      r_best_class <= '0;
      r_best_value <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_row        <= '0;
          r_cnt        <= '0;
          r_ovf_flags  <= '0;
          r_best_class <= '0;
          r_best_value <= '0;
        end
        S_ISSUE: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (i_done_row) begin
            r_cap     <= i_row_result;
            r_cap_ovf <= i_overflow;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STORE: begin
          for (int i = 0; i < NUM_ROWS; i++) begin
            if (r_row == 4'(i)) begin
              r_ovf_flags[i] <= r_ovf_flags[i] | r_cap_ovf;
            end
          end
          if ((r_row == 4'd0) || (r_cap > r_best_value)) begin
            r_best_value <= r_cap;
            r_best_class <= r_row;
          end
          if (w_next_state == S_ISSUE) begin
            r_row <= r_row + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_row_select   = r_row;
  assign o_in_sel       = r_row;
  assign o_begin_mult   = (r_state == S_ISSUE);
  assign o_w_result_ena = (r_state == S_STORE);
  assign o_clear_data   = (r_state == S_CLEAR);
  assign o_busy         = (r_state == S_CLEAR) || (r_state == S_ISSUE) ||
                          (r_state == S_WAIT)  || (r_state == S_STORE);
  assign o_done_calc    = (r_state == S_DONE);
  assign o_timeout_err  = (r_state == S_ERR);
  assign o_ovf_flags    = r_ovf_flags;
  assign o_best_class   = r_best_class;
  assign o_best_value   = r_best_value;

endmodule
